// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and defaults for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int TIMEOUT_CYCLES_DEF = 64;
  localparam int CNT_W_DEF = 7;

endpackage

// File: rtl/hazard_detect.sv
// Load-use compare: the load in EX writes a register the instruction in ID reads.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       mem_read_i,
  input  logic [4:0] rd_addr_i,
  input  logic [4:0] rs1_addr_i,
  input  logic [4:0] rs2_addr_i,
  output logic       load_use_o
);

  assign load_use_o = mem_read_i & (rd_addr_i != REG_ZERO) &
                      ((rd_addr_i == rs1_addr_i) | (rd_addr_i == rs2_addr_i));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer: memory-wait FSM with watchdog, load-use bubble, branch flush.
// Optional stall-cycle counter is built when HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int CNT_W          = CNT_W_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        IDEX_MemRead_i,
  input  logic [4:0]  IDEX_RDaddr_i,
  input  logic [4:0]  IFID_RS1addr_i,
  input  logic [4:0]  IFID_RS2addr_i,
  input  logic        Branch_taken_i,
  input  logic        EXMEM_MemAccess_i,
  input  logic        mem_ack_i,
  output logic        mem_req_o,
  output logic        PC_write_o,
  output logic        IFID_write_o,
  output logic        IFID_flush_o,
  output logic        IDEX_write_o,
  output logic        IDEX_flush_o,
  output logic        EXMEM_write_o,
  output logic        MEMWB_bubble_o,
  output logic        err_o,
  output logic [31:0] perf_stall_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             frozen_s;
  logic             load_use_s;

  hazard_detect u_hazard_detect (
    .mem_read_i (IDEX_MemRead_i),
    .rd_addr_i  (IDEX_RDaddr_i),
    .rs1_addr_i (IFID_RS1addr_i),
    .rs2_addr_i (IFID_RS2addr_i),
    .load_use_o (load_use_s)
  );

  // Next state, watchdog and control outputs from current state and inputs
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    err_d          = err_q;
    frozen_s       = 1'b0;
    mem_req_o      = 1'b0;
    PC_write_o     = 1'b1;
    IFID_write_o   = 1'b1;
    IFID_flush_o   = 1'b0;
    IDEX_write_o   = 1'b1;
    IDEX_flush_o   = 1'b0;
    EXMEM_write_o  = 1'b1;
    MEMWB_bubble_o = 1'b0;

    case (state_q)
      RUN: begin
        mem_req_o = EXMEM_MemAccess_i;
        if (EXMEM_MemAccess_i && !mem_ack_i) begin
          frozen_s = 1'b1;
          state_d  = MEM_WAIT;
          cnt_d    = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      MEM_WAIT: begin
        mem_req_o = 1'b1;
        if (mem_ack_i) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          // Abort: pipeline released but the access result is dropped
          MEMWB_bubble_o = 1'b1;
          err_d          = 1'b1;
          state_d        = RUN;
          cnt_d          = '0;
        end else begin
          frozen_s = 1'b1;
          cnt_d    = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase

    if (frozen_s) begin
      PC_write_o     = 1'b0;
      IFID_write_o   = 1'b0;
      IDEX_write_o   = 1'b0;
      EXMEM_write_o  = 1'b0;
      MEMWB_bubble_o = 1'b1;
    end else if (load_use_s) begin
      PC_write_o   = 1'b0;
      IFID_write_o = 1'b0;
      IDEX_flush_o = 1'b1;
    end else if (Branch_taken_i) begin
      IFID_flush_o = 1'b1;
    end else begin
      IFID_flush_o = 1'b0;
    end
  end

  // FSM, watchdog count and sticky error flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign err_o = err_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_q, perf_d;

  // Saturating count of cycles with the PC held
  always_comb begin
    if (!PC_write_o && (perf_q != 32'hFFFF_FFFF)) begin
      perf_d = perf_q + 32'd1;
    end else begin
      perf_d = perf_q;
    end
  end

  // Stall counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_q <= 32'd0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_stall_cnt_o = perf_q;
`else
  assign perf_stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl (watchdog shortened to 4 cycles).
module tb_pipe_hazard_ctrl;

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {mem_req, PC_w, IFID_w, IFID_flush, IDEX_w, IDEX_flush, EXMEM_w, MEMWB_bubble}
  localparam logic [7:0] C_IDLE   = 8'b0110_1010;
  localparam logic [7:0] C_ZWAIT  = 8'b1110_1010;
  localparam logic [7:0] C_FREEZE = 8'b1000_0001;
  localparam logic [7:0] C_LU     = 8'b0000_1110;
  localparam logic [7:0] C_BR     = 8'b0111_1010;
  localparam logic [7:0] C_ACK_LU = 8'b1000_1110;
  localparam logic [7:0] C_ABORT  = 8'b1110_1011;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic IDEX_MemRead_i = 1'b0;
  logic [4:0] IDEX_RDaddr_i = 5'd0;
  logic [4:0] IFID_RS1addr_i = 5'd0;
  logic [4:0] IFID_RS2addr_i = 5'd0;
  logic Branch_taken_i = 1'b0;
  logic EXMEM_MemAccess_i = 1'b0;
  logic mem_ack_i = 1'b0;
  logic mem_req_o, PC_write_o, IFID_write_o, IFID_flush_o, IDEX_write_o;
  logic IDEX_flush_o, EXMEM_write_o, MEMWB_bubble_o, err_o;
  logic [31:0] perf_stall_cnt_o;
  logic [7:0] ctl;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [31:0] exp_perf = 32'd0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(7)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .IDEX_MemRead_i(IDEX_MemRead_i), .IDEX_RDaddr_i(IDEX_RDaddr_i),
    .IFID_RS1addr_i(IFID_RS1addr_i), .IFID_RS2addr_i(IFID_RS2addr_i),
    .Branch_taken_i(Branch_taken_i), .EXMEM_MemAccess_i(EXMEM_MemAccess_i),
    .mem_ack_i(mem_ack_i), .mem_req_o(mem_req_o), .PC_write_o(PC_write_o),
    .IFID_write_o(IFID_write_o), .IFID_flush_o(IFID_flush_o),
    .IDEX_write_o(IDEX_write_o), .IDEX_flush_o(IDEX_flush_o),
    .EXMEM_write_o(EXMEM_write_o), .MEMWB_bubble_o(MEMWB_bubble_o),
    .err_o(err_o), .perf_stall_cnt_o(perf_stall_cnt_o)
  );

  assign ctl = {mem_req_o, PC_write_o, IFID_write_o, IFID_flush_o,
                IDEX_write_o, IDEX_flush_o, EXMEM_write_o, MEMWB_bubble_o};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs just after an edge, check at the falling edge, then advance
  task automatic cyc(input string tag, input logic acc, input logic ack,
                     input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic br,
                     input logic [7:0] exp_ctl, input logic exp_err);
    EXMEM_MemAccess_i = acc;
    mem_ack_i         = ack;
    IDEX_MemRead_i    = mr;
    IDEX_RDaddr_i     = rd;
    IFID_RS1addr_i    = rs1;
    IFID_RS2addr_i    = rs2;
    Branch_taken_i    = br;
    @(negedge clk);
    check({tag, ".ctl"}, {24'd0, ctl}, {24'd0, exp_ctl});
    check({tag, ".err"}, {31'd0, err_o}, {31'd0, exp_err});
    check({tag, ".perf"}, perf_stall_cnt_o, exp_perf);
    if (PERF && !exp_ctl[6] && !rst_i) exp_perf = exp_perf + 32'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    cyc("reset", 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, C_IDLE, 1'b0);
    rst_i = 1'b0;
    exp_perf = 32'd0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset();
    cyc("idle", 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, C_IDLE, 1'b0);

    cyc("zwait", 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, C_ZWAIT, 1'b0);
    cyc("zwait_after", 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, C_IDLE, 1'b0);

    for (int i = 0; i < 3; i++)
      cyc("mem3_wait", 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, C_FREEZE, 1'b0);
    cyc("mem3_ack", 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, C_ZWAIT, 1'b0);
    cyc("mem3_after", 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, C_IDLE, 1'b0);

    cyc("lu_rs2", 1'b0, 1'b0, 1'b1, 5'd5, 5'd1, 5'd5, 1'b0, C_LU, 1'b0);
    cyc("lu_next", 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd5, 1'b0, C_IDLE, 1'b0);
    cyc("lu_rs1", 1'b0, 1'b0, 1'b1, 5'd7, 5'd7, 5'd2, 1'b0, C_LU, 1'b0);
    cyc("lu_r0", 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, C_IDLE, 1'b0);
    cyc("lu_nomatch", 1'b0, 1'b0, 1'b1, 5'd9, 5'd8, 5'd10, 1'b0, C_IDLE, 1'b0);

    cyc("lu_br", 1'b0, 1'b0, 1'b1, 5'd5, 5'd0, 5'd5, 1'b1, C_LU, 1'b0);
    cyc("br_retry", 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1, C_BR, 1'b0);

    cyc("wait_sup0", 1'b1, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, C_FREEZE, 1'b0);
    cyc("wait_sup1", 1'b1, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, C_FREEZE, 1'b0);
    cyc("wait_ack_lu", 1'b1, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, C_ACK_LU, 1'b0);
    cyc("wait_ack_next", 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, C_IDLE, 1'b0);

    for (int i = 0; i < 3; i++)
      cyc("to_freeze", 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, C_FREEZE, 1'b0);
    cyc("to_abort", 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, C_ABORT, 1'b0);
    cyc("to_err", 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, C_IDLE, 1'b1);
    cyc("to_sticky", 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, C_IDLE, 1'b1);
    rst_i = 1'b1;
    cyc("to_rst", 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, C_IDLE, 1'b1);
    rst_i = 1'b0;
    exp_perf = 32'd0;
    cyc("to_cleared", 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, C_IDLE, 1'b0);

    cyc("rmw0", 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, C_FREEZE, 1'b0);
    cyc("rmw1", 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, C_FREEZE, 1'b0);
    rst_i = 1'b1;
    cyc("rmw_rst", 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, C_FREEZE, 1'b0);
    rst_i = 1'b0;
    exp_perf = 32'd0;
    cyc("rmw_after", 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, C_IDLE, 1'b0);
    cyc("rmw_run", 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, C_ZWAIT, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives write-enable and bubble/flush controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves three hazard classes in fixed priority:
  1. multi-cycle data-memory wait (req/ack handshake, FSM);
  2. load-use hazard (one bubble);
  3. taken-branch flush.
- Includes a watchdog that aborts a hung memory access.

Parameters:
- TIMEOUT_CYCLES, 64, max cycles in MEM_WAIT before forced abort (≥2)
- CNT_W, 7, width of watchdog counter; must hold TIMEOUT_CYCLES

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  synchronous active-high reset
- IDEX_MemRead_i  in  1  instruction in EX is a load
- IDEX_RDaddr_i  in  5  destination register of instruction in EX
- IFID_RS1addr_i  in  5  rs1 of instruction in ID
- IFID_RS2addr_i  in  5  rs2 of instruction in ID
- Branch_taken_i  in  1  branch in ID resolved taken
- EXMEM_MemAccess_i  in  1  instruction in MEM does load or store
- mem_ack_i  in  1  data memory completes access this cycle
- mem_req_o  out  1  data memory request
- PC_write_o  out  1  PC register enable
- IFID_write_o  out  1  IF/ID enable
- IFID_flush_o  out  1  IF/ID loads NOP
- IDEX_write_o  out  1  ID/EX enable
- IDEX_flush_o  out  1  ID/EX loads bubble (control bits 0)
- EXMEM_write_o  out  1  EX/MEM enable
- MEMWB_bubble_o  out  1  MEM/WB loads RDaddr=0, MemtoReg=0
- err_o  out  1  sticky watchdog-abort flag
- perf_stall_cnt_o  out  32  stall cycle count (see Optional Feature)

Behaviour:
- Clock and reset: one clock clk_i; reset rst_i is synchronous, active-high.
- Reset:
  - state=RUN, watchdog count=0, err_o=0, perf_stall_cnt_o=0.
  - Outputs take RUN values for the current inputs, so with idle inputs: all *_write_o=1, flush/bubble=0, mem_req_o=0.
- FSM states: RUN, MEM_WAIT. All outputs are combinational from state + inputs (0-cycle latency).
- mem_req_o = (RUN & EXMEM_MemAccess_i) | MEM_WAIT.
- RUN with EXMEM_MemAccess_i=1 and mem_ack_i=0:
  - Freeze: PC/IFID/IDEX/EXMEM write=0, MEMWB_bubble=1.
  - Next state MEM_WAIT, count=1.
- RUN with access and ack same cycle: zero-wait, no stall, stay RUN.
- MEM_WAIT with ack=0:
  - Freeze as above; count++.
  - Load-use and branch logic are suppressed; frozen registers preserve those inputs.
- MEM_WAIT with ack=1:
  - All writes=1, bubble=0; load-use/branch evaluated normally this cycle.
  - Next state RUN, count=0.
- Watchdog: in MEM_WAIT with ack=0 and count==TIMEOUT_CYCLES-1:
  - Release all writes with MEMWB_bubble=1 (access dropped); mem_req_o still 1 this cycle.
  - err_o<=1; next RUN; count=0.
  - err_o stays set until rst_i.
- Load-use condition (only when not frozen by memory): IDEX_MemRead_i & IDEX_RDaddr_i!=0 & (RDaddr==RS1 | RDaddr==RS2).
  - Action: PC_write=0, IFID_write=0, IDEX_flush=1, EXMEM_write=1.
  - Exactly one bubble, because the next cycle the load has left EX.
- Branch flush (not frozen, no load-use): Branch_taken_i → IFID_flush=1, all writes=1.
- Load-use and branch in the same cycle: load-use wins, branch is suppressed. The branch re-evaluates the next cycle with correct operands.
- Reset asserted mid-MEM_WAIT: next cycle RUN, count=0, err_o=0; the in-flight request is abandoned.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined: perf_stall_cnt_o increments by 1 each cycle PC_write_o=0, from either a memory or a load-use stall.
  - Saturates at 0xFFFF_FFFF.
  - Cleared by rst_i.
- Undefined: the port stays present, is tied to 0, and no counter flops are built.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - FSM state encoding (RUN=1'b0, MEM_WAIT=1'b1);
  - REG_ZERO=5'd0;
  - default TIMEOUT_CYCLES.
- One natural sub-module: hazard_detect, the purely combinational load-use compare.
- FSM, watchdog and perf counter stay in the top.

Test Plan:
- Zero-wait memory: MemAccess=1, ack=1 same cycle → mem_req=1, all writes=1, state stays RUN, perf count unchanged.
- 3-cycle memory: MemAccess=1, ack low 3 cycles then high → writes=0 and MEMWB_bubble=1 for cycles 0-2; cycle 3 all writes=1; perf count=3.
- Load-use: IDEX_MemRead=1, RDaddr=5, RS2=5 → PC_write=0, IFID_write=0, IDEX_flush=1 for exactly 1 cycle. Repeat with RDaddr=0 → no stall.
- Load-use plus Branch_taken=1 together → IFID_flush=0, IDEX_flush=1; next cycle with branch still high → IFID_flush=1.
- Timeout: TIMEOUT_CYCLES=4, ack never → freeze cycles 0-2; cycle 3 release with MEMWB_bubble=1; err_o=1 from cycle 4; rst_i clears it.
- Reset mid-wait: rst_i at cycle 2 of MEM_WAIT → next cycle mem_req=0 (MemAccess=0), state RUN, perf count=0.
